// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for the binary up-counter: start/pause/clear control,
// programmable terminal count, clock prescaler, one-shot or auto-reload runs.
module counter_seq_ctrl #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               pause,
  input  logic               clear,
  input  logic               mode_auto,
  input  logic [WIDTH-1:0]   period,
  input  logic [PRESC_W-1:0] prescale,
  output logic [WIDTH-1:0]   counter,
  output logic               upper,
  output logic               done,
  output logic               busy,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t             st, st_n;
  logic [WIDTH-1:0]   cnt_n;
  logic [PRESC_W-1:0] pcnt, pcnt_n;
  logic [WIDTH-1:0]   lat_period, lat_period_n;
  logic [PRESC_W-1:0] lat_presc, lat_presc_n;
  logic               lat_auto, lat_auto_n;
  logic               done_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st         <= IDLE;
      counter    <= '0;
      pcnt       <= '0;
      lat_period <= '0;
      lat_presc  <= '0;
      lat_auto   <= 1'b0;
      done       <= 1'b0;
    end else begin
      st         <= st_n;
      counter    <= cnt_n;
      pcnt       <= pcnt_n;
      lat_period <= lat_period_n;
      lat_presc  <= lat_presc_n;
      lat_auto   <= lat_auto_n;
      done       <= done_n;
    end
  end

  // Priority: clear > start > pause > count step.
  always_comb begin
    st_n         = st;
    cnt_n        = counter;
    pcnt_n       = pcnt;
    lat_period_n = lat_period;
    lat_presc_n  = lat_presc;
    lat_auto_n   = lat_auto;
    done_n       = 1'b0;
    if (clear) begin
      st_n   = IDLE;
      cnt_n  = '0;
      pcnt_n = '0;
    end else if (start && (st == IDLE || st == DONE)) begin
      lat_period_n = period;
      lat_presc_n  = prescale;
      lat_auto_n   = mode_auto;
      cnt_n        = '0;
      pcnt_n       = '0;
      st_n         = RUN;
    end else begin
      case (st)
        RUN: begin
          if (pause) begin
            st_n = PAUSED;
          end else if (pcnt == lat_presc) begin
            pcnt_n = '0;
            if (counter == lat_period) begin
              done_n = 1'b1;
              if (lat_auto) cnt_n = '0;
              else          st_n  = DONE;
            end else begin
              cnt_n = counter + 1'b1;
            end
          end else begin
            pcnt_n = pcnt + 1'b1;
          end
        end
        // Prescaler keeps its frozen phase across a pause.
        PAUSED: if (!pause) st_n = RUN;
        default: ;
      endcase
    end
  end

  assign upper = counter[WIDTH-1];
  assign busy  = (st == RUN) || (st == PAUSED);
  assign state = st;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: directed vectors, an activity-count model that
// predicts the outputs every cycle, and literal spot checks.
module tb_counter_seq_ctrl;
  localparam int W  = 4;
  localparam int PW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, pause = 1'b0, clear = 1'b0, mode_auto = 1'b0;
  logic [W-1:0]  period = '0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  counter;
  logic          upper, done, busy;
  logic [1:0]    state;

  counter_seq_ctrl #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pause(pause),
    .clear(clear), .mode_auto(mode_auto), .period(period),
    .prescale(prescale), .counter(counter), .upper(upper), .done(done),
    .busy(busy), .state(state)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;

  // Model: phase (0 idle,1 run,2 paused,3 done) plus the number of unpaused
  // run clocks since start; the count follows from plain division.
  int ph = 0, act = 0, mp = 0, mps = 0, steps_m = 0;
  bit ma = 1'b0, mdone = 1'b0;

  function automatic int exp_cnt();
    int s;
    if (ph == 0) return 0;
    if (ph == 3) return mp;
    s = act / (mps + 1);
    return ma ? (s % (mp + 1)) : s;
  endfunction

  task automatic chk(input string nm, input int got, input int exp_v);
    n_chk++;
    if (got != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp_v, $time);
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ph = 0; act = 0; mp = 0; mps = 0; ma = 1'b0; mdone = 1'b0;
    end else begin
      mdone = 1'b0;
      if (clear) begin
        ph = 0; act = 0;
      end else if (start && (ph == 0 || ph == 3)) begin
        mp = period; mps = prescale; ma = mode_auto; act = 0; ph = 1;
      end else if (ph == 1) begin
        if (pause) ph = 2;
        else begin
          act++;
          if (act % (mps + 1) == 0) begin
            steps_m = act / (mps + 1);
            if (ma) begin
              if (steps_m % (mp + 1) == 0) mdone = 1'b1;
            end else if (steps_m == mp + 1) begin
              mdone = 1'b1; ph = 3;
            end
          end
        end
      end else if (ph == 2 && !pause) begin
        ph = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("cyc_counter", counter, exp_cnt());
      chk("cyc_upper", upper, (exp_cnt() >> (W - 1)) & 1);
      chk("cyc_done", done, mdone);
      chk("cyc_busy", busy, (ph == 1 || ph == 2) ? 1 : 0);
      chk("cyc_state", state, ph);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    ticks(2);
    chk("rst_counter", counter, 0);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    tick();

    // One-shot, period 5, prescale 0
    mode_auto = 1'b0; period = 5; prescale = 0; start = 1'b1;
    tick(); start = 1'b0;
    chk("os_first", counter, 0);
    chk("os_run", state, 1);
    for (int i = 1; i <= 5; i++) begin
      tick(); chk("os_count", counter, i);
    end
    tick();
    chk("os_done", done, 1);
    chk("os_hold", counter, 5);
    chk("os_state", state, 3);
    chk("os_busy", busy, 0);
    tick();
    chk("os_done_once", done, 0);
    chk("os_stay", state, 3);

    // Start from DONE: auto, period 15
    mode_auto = 1'b1; period = 15; start = 1'b1;
    tick(); start = 1'b0;
    chk("a15_start", counter, 0);
    for (int i = 1; i <= 15; i++) begin
      tick(); chk("a15_upper", upper, (i >= 8) ? 1 : 0);
    end
    tick();
    chk("a15_wrap", counter, 0);
    chk("a15_done", done, 1);
    ticks(9);
    chk("a15_nine", counter, 9);
    chk("a15_upper9", upper, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_counter", counter, 0);
    chk("arst_upper", upper, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_state", state, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    tick();

    // Auto, period 3, prescale 2; input changes mid-run are ignored
    period = 3; prescale = 2; start = 1'b1;
    tick(); start = 1'b0;
    ticks(3);
    chk("p3_first_step", counter, 1);
    period = 9; prescale = 0;
    ticks(5);
    start = 1'b1;
    tick(); start = 1'b0;
    ticks(3);
    chk("p3_done12", done, 1);
    chk("p3_wrap12", counter, 0);
    ticks(12);
    chk("p3_done24", done, 1);

    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_state", state, 0);
    chk("clr_counter", counter, 0);
    pause = 1'b1; tick(); pause = 1'b0;
    chk("idle_pause", state, 0);

    // Pause at counter 3 with prescaler phase 1
    period = 7; prescale = 2; start = 1'b1;
    tick(); start = 1'b0;
    ticks(10);
    chk("pz_pre", counter, 3);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pz_state", state, 2);
      chk("pz_counter", counter, 3);
      chk("pz_busy", busy, 1);
    end
    pause = 1'b0;
    tick();
    chk("pz_resume", state, 1);
    chk("pz_resume_cnt", counter, 3);
    ticks(2);
    chk("pz_step", counter, 4);

    // clear beats start in RUN
    clear = 1'b1; start = 1'b1; period = 2;
    tick(); clear = 1'b0; start = 1'b0;
    chk("cs_state", state, 0);
    chk("cs_counter", counter, 0);

    // period 0, auto, prescale 0: done every clock
    mode_auto = 1'b1; period = 0; prescale = 0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk("p0a_done1", done, 1);
    tick(); chk("p0a_done2", done, 1);
    pause = 1'b1; tick();
    chk("p0a_paused", state, 2);
    clear = 1'b1; tick(); clear = 1'b0; pause = 1'b0;
    chk("clr_paused", state, 0);

    // period 0, one-shot, prescale 1
    mode_auto = 1'b0; period = 0; prescale = 1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("p0o_run", state, 1);
    chk("p0o_nodone", done, 0);
    tick();
    chk("p0o_done", done, 1);
    chk("p0o_state", state, 3);
    chk("p0o_counter", counter, 0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_done", state, 0);
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencing controller for the team's small binary up-counter datapath, which exposes a counter value plus an `upper` flag equal to its MSB.
- Adds start/pause/clear control, a programmable terminal count (period), a clock prescaler, one-shot vs auto-reload modes, and a terminal-count pulse.
- Sits between a host/control FSM and any logic consuming the count or the `upper` half-period flag.

Parameters:
- WIDTH, 4, counter width in bits
- PRESC_W, 4, prescaler width in bits

Ports:
- clock  input  1  sole clock; all state updates on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  begin a count run; latches period/prescale/mode_auto
- pause  input  1  level; freezes a run while high
- clear  input  1  synchronous abort back to IDLE
- mode_auto  input  1  1 = auto-reload (periodic), 0 = one-shot
- period  input  WIDTH  terminal count value
- prescale  input  PRESC_W  clocks per step minus 1
- counter  output  WIDTH  current count
- upper  output  1  always equal to counter[WIDTH-1]
- done  output  1  one-cycle terminal-count pulse
- busy  output  1  high in RUN or PAUSED
- state  output  2  IDLE=00, RUN=01, PAUSED=10, DONE=11

Behaviour:
- Reset: while reset_n=0, asynchronously force:
  - counter=0, upper=0, done=0, busy=0, state=IDLE
  - prescaler count=0
  - latched period, prescale and mode all 0
- Priority per edge: clear > start > pause > count step.
- clear=1, any state:
  - next state IDLE
  - counter=0, prescaler count=0, done=0
  - latched config unchanged
- start=1 in IDLE or DONE:
  - latch period, prescale and mode_auto
  - counter=0, prescaler count=0, next state RUN
- start=1 in RUN or PAUSED: ignored; latched config is not updated.
- RUN, pause=0:
  - If prescaler count == latched prescale: prescaler count=0 and a step occurs.
  - Otherwise prescaler count increments and there is no step.
- Step, counter != latched period: counter += 1.
- Step, counter == latched period (terminal):
  - done=1 for exactly this cycle (registered, coincident with the counter update).
  - Auto mode: counter=0, stay in RUN.
  - One-shot mode: counter holds at period, next state DONE.
- Count sequence and timing:
  - A full run covers period+1 steps (0..period inclusive).
  - First step occurs prescale+1 edges after the edge that enters RUN.
- RUN with pause=1: next state PAUSED; counter and prescaler count frozen; no step that cycle.
- PAUSED:
  - Holds everything while pause=1.
  - Returns to RUN when pause=0; the prescaler resumes from its frozen value.
- DONE:
  - counter holds, done=0, busy=0.
  - Leaves DONE only via start or clear.
- IDLE: counter=0; pause has no effect.
- Boundary values:
  - period=0: every step is terminal. In auto mode done pulses once per prescale+1 clocks. In one-shot mode, DONE is entered on the first step.
  - prescale=0: one step per clock.
  - Max period (2^WIDTH-1) in auto mode reproduces the plain free-running wrap counter.
- upper and busy are combinational from counter and state; no extra latency.
- done is never high in two consecutive cycles unless period=0, prescale=0 and auto mode.

Test Plan:
- Reset: run auto period=15; drop reset_n mid-cycle with counter=9 -> counter, upper, done, busy go 0 and state=00 immediately, without waiting for a clock edge.
- One-shot, period=5, prescale=0, 1-cycle start pulse:
  - counter 0,1,2,3,4,5 on successive edges.
  - Next edge: done=1 for one cycle, counter stays 5, state=11, busy=0.
- Auto, period=15, prescale=0:
  - counter 0..15 then wraps to 0.
  - upper=1 exactly for counts 8..15.
  - done pulses once every 16 clocks, coincident with 15->0.
- Auto, period=3, prescale=2:
  - counter advances every 3rd clock.
  - done every 12 clocks.
  - Changing period/prescale inputs mid-run has no effect until the next start after clear.
- Pause at counter=3, prescale=2, prescaler count=1; hold pause 4 cycles:
  - state=10, counter=3, busy=1 throughout.
  - After release: counter=4 exactly 2 clocks after returning to RUN.
- Priority:
  - clear and start together in RUN -> state=00, counter=0.
  - start while RUN with a new period -> ignored.
  - start in DONE -> restarts from 0 with the new latched config.
